draw_rect_fill: RTL and testbench

DRAW_RECT_FILL -- requirements
Module: draw_rect_fill

---
 rtl/draw_rect_fill.sv | 160 ++++++++++++++++
 tb/tb_draw_rect_fill.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/draw_rect_fill.sv
// draw_rect_fill: streams the pixels of an axis-aligned rectangle in raster
// order, one per accepted ready cycle, in either a solid colour or a checker
// pattern. Outputs are registered; ready=0 freezes the presented pixel.
// Optional macro RECT_CLIP_EN: clip the rectangle to SCREEN_WIDTH x
// SCREEN_HEIGHT when the request is accepted. Without it, coordinates wrap.
module draw_rect_fill #(
  parameter int X_WIDTH       = 8,
  parameter int Y_WIDTH       = 7,
  parameter int COLOUR_WIDTH  = 3,
  parameter int CHECK_LOG2    = 2,
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [X_WIDTH-1:0]      x0,
  input  logic [Y_WIDTH-1:0]      y0,
  input  logic [X_WIDTH-1:0]      rect_w,
  input  logic [Y_WIDTH-1:0]      rect_h,
  input  logic [COLOUR_WIDTH-1:0] fill_colour,
  input  logic [COLOUR_WIDTH-1:0] alt_colour,
  input  logic                    mode,
  input  logic                    ready,
  output logic [X_WIDTH-1:0]      x,
  output logic [Y_WIDTH-1:0]      y,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    done
);

  localparam int OW = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [X_WIDTH-1:0]      x0_q, x0_d, w_q, w_d, xo_q, xo_d, x_q, x_d;
  logic [Y_WIDTH-1:0]      y0_q, y0_d, h_q, h_d, yo_q, yo_d, y_q, y_d;
  logic [COLOUR_WIDTH-1:0] fill_q, fill_d, alt_q, alt_d, colour_q, colour_d;
  logic                    mode_q, mode_d;
  logic                    plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  // Effective size of the incoming request (clipped when enabled)
  logic [X_WIDTH-1:0] w_eff;
  logic [Y_WIDTH-1:0] h_eff;
  logic               empty;

`ifdef RECT_CLIP_EN
  logic [X_WIDTH:0] x_room;
  logic [Y_WIDTH:0] y_room;

  // Room left on screen from the origin, one bit wider so the subtraction
  // and comparison never overflow.
  always_comb begin
    x_room = (X_WIDTH+1)'(SCREEN_WIDTH) - {1'b0, x0};
    y_room = (Y_WIDTH+1)'(SCREEN_HEIGHT) - {1'b0, y0};
    w_eff  = '0;
    h_eff  = '0;
    if ({1'b0, x0} < (X_WIDTH+1)'(SCREEN_WIDTH))
      w_eff = ({1'b0, rect_w} < x_room) ? rect_w : x_room[X_WIDTH-1:0];
    if ({1'b0, y0} < (Y_WIDTH+1)'(SCREEN_HEIGHT))
      h_eff = ({1'b0, rect_h} < y_room) ? rect_h : y_room[Y_WIDTH-1:0];
  end
`else
  assign w_eff = rect_w;
  assign h_eff = rect_h;
`endif

  assign empty = (w_eff == '0) || (h_eff == '0);

  // Transfer handshake and end-of-row / end-of-rectangle detection
  logic xfer, last_col, last_pix;
  assign xfer     = (state_q == S_DRAW) && ready;
  assign last_col = (xo_q == w_q - X_WIDTH'(1));
  assign last_pix = last_col && (yo_q == h_q - Y_WIDTH'(1));

  // State and datapath registers; reset abandons any fill in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x0_q     <= '0; y0_q <= '0; w_q <= '0; h_q <= '0;
      fill_q   <= '0; alt_q <= '0; mode_q <= 1'b0;
      xo_q     <= '0; yo_q <= '0;
      x_q      <= '0; y_q <= '0; colour_q <= '0;
      plot_q   <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d; y0_q <= y0_d; w_q <= w_d; h_q <= h_d;
      fill_q   <= fill_d; alt_q <= alt_d; mode_q <= mode_d;
      xo_q     <= xo_d; yo_q <= yo_d;
      x_q      <= x_d; y_q <= y_d; colour_q <= colour_d;
      plot_q   <= plot_d; busy_q <= busy_d; done_q <= done_d;
    end
  end

  // Next-state: empty requests go straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = empty ? S_DONE : S_DRAW;
      S_DRAW:  if (xfer && last_pix) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Offset stepping and registered pixel outputs; everything holds by default
  logic [X_WIDTH-1:0] nxo;
  logic [Y_WIDTH-1:0] nyo;
  logic [OW-1:0]      diff;

  always_comb begin
    x0_d = x0_q; y0_d = y0_q; w_d = w_q; h_d = h_q;
    fill_d = fill_q; alt_d = alt_q; mode_d = mode_q;
    xo_d = xo_q; yo_d = yo_q;
    x_d = x_q; y_d = y_q; colour_d = colour_q;
    plot_d = plot_q; busy_d = busy_q; done_d = 1'b0;
    nxo  = last_col ? '0 : xo_q + X_WIDTH'(1);
    nyo  = last_col ? yo_q + Y_WIDTH'(1) : yo_q;
    diff = OW'(nxo) ^ OW'(nyo);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d = x0; y0_d = y0; w_d = w_eff; h_d = h_eff;
          fill_d = fill_colour; alt_d = alt_colour; mode_d = mode;
          xo_d = '0; yo_d = '0;
          if (empty) begin
            done_d = 1'b1;
          end else begin
            // Offset (0,0) is always a fill_colour tile
            x_d = x0; y_d = y0; colour_d = fill_colour;
            plot_d = 1'b1; busy_d = 1'b1;
          end
        end
      end
      S_DRAW: begin
        if (xfer) begin
          if (last_pix) begin
            plot_d = 1'b0; busy_d = 1'b0; done_d = 1'b1;
          end else begin
            xo_d = nxo; yo_d = nyo;
            x_d = x0_q + nxo;
            y_d = y0_q + nyo;
            colour_d = (mode_q && diff[CHECK_LOG2]) ? alt_q : fill_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_draw_rect_fill.sv
// Bench for draw_rect_fill: directed and random fills checked against a
// pixel-list model built from nested loops. Honours RECT_CLIP_EN.
module tb_draw_rect_fill;
  localparam int XW = 8, YW = 7, CW = 3, CL = 2, SW = 160, SH = 120;

  logic          clk = 1'b0;
  logic          reset, start, mode, ready;
  logic [XW-1:0] x0, rect_w, x;
  logic [YW-1:0] y0, rect_h, y;
  logic [CW-1:0] fill_colour, alt_colour, colour;
  logic          plot, busy, done;

  int nchk = 0;
  int nerr = 0;

  draw_rect_fill #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW),
                   .CHECK_LOG2(CL), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)) dut (
    .clock(clk), .reset(reset), .start(start), .x0(x0), .y0(y0),
    .rect_w(rect_w), .rect_h(rect_h), .fill_colour(fill_colour),
    .alt_colour(alt_colour), .mode(mode), .ready(ready),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to completion. stall = number of forced
  // ready=0 cycles at the start; prob = percent chance of ready=1 afterwards.
  task automatic run_fill(input int ax0, input int ay0, input int aw, input int ah,
                          input int afc, input int aac, input int amode,
                          input int stall, input int prob, input int exp_cycles);
    int xs[$], ys[$], cs[$];
    int ew, eh, budget, st, cyc;
    ew = aw; eh = ah;
`ifdef RECT_CLIP_EN
    ew = (ax0 >= SW) ? 0 : ((aw < SW - ax0) ? aw : SW - ax0);
    eh = (ay0 >= SH) ? 0 : ((ah < SH - ay0) ? ah : SH - ay0);
`endif
    for (int j = 0; j < eh; j++)
      for (int i = 0; i < ew; i++) begin
        xs.push_back((ax0 + i) % (1 << XW));
        ys.push_back((ay0 + j) % (1 << YW));
        cs.push_back((amode != 0 && (((i ^ j) >> CL) & 1) != 0) ? aac : afc);
      end
    @(negedge clk);
    x0 = XW'(ax0); y0 = YW'(ay0); rect_w = XW'(aw); rect_h = YW'(ah);
    fill_colour = CW'(afc); alt_colour = CW'(aac); mode = amode[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // The request is latched; later input changes must not matter
    x0 = XW'($urandom); y0 = YW'($urandom); rect_w = XW'($urandom);
    rect_h = YW'($urandom); fill_colour = CW'($urandom);
    alt_colour = CW'($urandom); mode = 1'($urandom);
    st = stall; budget = 0; cyc = 0;
    while (xs.size() > 0 && budget < 2000) begin
      chk("plot", 32'(plot), 1);
      chk("busy", 32'(busy), 1);
      chk("done_early", 32'(done), 0);
      chk("x", 32'(x), xs[0]);
      chk("y", 32'(y), ys[0]);
      chk("colour", 32'(colour), cs[0]);
      start = 1'($urandom);
      if (st > 0) begin ready = 1'b0; st--; end
      else ready = ($urandom_range(99) < prob);
      if (ready) begin void'(xs.pop_front()); void'(ys.pop_front()); void'(cs.pop_front()); end
      @(negedge clk);
      budget++; cyc++;
    end
    start = 1'b0;
    chk("timeout", 32'(budget < 2000), 1);
    if (exp_cycles >= 0) chk("draw_cycles", cyc, exp_cycles);
    chk("done_pulse", 32'(done), 1);
    chk("plot_off", 32'(plot), 0);
    chk("busy_off", 32'(busy), 0);
    @(negedge clk);
    chk("done_once", 32'(done), 0);
    chk("plot_idle", 32'(plot), 0);
    ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b1;
    x0 = '0; y0 = '0; rect_w = '0; rect_h = '0; fill_colour = '0; alt_colour = '0;
    repeat (2) @(negedge clk);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_colour", 32'(colour), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;

    // Solid 3x2 with ready high: exactly w*h draw cycles
    run_fill(10, 5, 3, 2, 3'b100, 3'b011, 0, 0, 100, 6);
    // Backpressure on the first pixel: 3 stalls + 2 transfers
    run_fill(7, 9, 2, 1, 3'b010, 3'b101, 0, 3, 100, 5);
    // Checker row: 001 x4 then 110 x4
    run_fill(0, 0, 8, 1, 3'b001, 3'b110, 1, 0, 100, 8);
    // Checker block spanning two tile rows
    run_fill(3, 2, 9, 6, 3'b111, 3'b000, 1, 0, 100, 54);
    // Empty rectangles: done immediately, no plot
    run_fill(20, 20, 0, 5, 3'b001, 3'b001, 0, 0, 100, 0);
    run_fill(20, 20, 4, 0, 3'b001, 3'b001, 1, 0, 100, 0);
`ifdef RECT_CLIP_EN
    run_fill(158, 119, 5, 4, 3'b101, 3'b010, 0, 0, 100, 2);
    run_fill(170, 10, 5, 4, 3'b101, 3'b010, 0, 0, 100, 0);
`else
    // Coordinates wrap modulo 2^width
    run_fill(254, 126, 4, 3, 3'b101, 3'b010, 1, 0, 100, 12);
`endif

    // Reset in the middle of a 5x4 fill after 4 transfers
    @(negedge clk);
    x0 = 8'd20; y0 = 7'd30; rect_w = 8'd5; rect_h = 7'd4;
    fill_colour = 3'b110; alt_colour = 3'b001; mode = 1'b0; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_plot", 32'(plot), 1);
    chk("mid_x", 32'(x), 24);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_x", 32'(x), 0);
    chk("abort_y", 32'(y), 0);
    chk("abort_colour", 32'(colour), 0);
    chk("abort_plot", 32'(plot), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_resume_plot", 32'(plot), 0);
      chk("no_resume_done", 32'(done), 0);
    end
    run_fill(1, 1, 2, 2, 3'b011, 3'b100, 0, 0, 100, 4);

    // Random requests under random backpressure
    for (int n = 0; n < 10; n++)
      run_fill($urandom_range(255), $urandom_range(127), $urandom_range(6),
               $urandom_range(4), $urandom_range(7), $urandom_range(7),
               $urandom_range(1), $urandom_range(2), 60, -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
